alu_result_framer: RTL

Downstream stage of the 4-bit ALU. It captures each registered ALU result (8-bit result, carry, overflow) into a small FIFO and serializes every entry as a fixed 13-bit, UART-style frame on a single pin. This lets a host log ALU output over one wire without stalling the ALU. A sticky flag records any result lost while the FIFO was full.

---
 rtl/alu_result_framer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_result_framer.sv
// Buffers registered ALU results in a small FIFO and serializes each one as a 13-bit
// UART-style frame: start, result[7:0] LSB first, carry, overflow, even parity, stop.
module alu_result_framer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_result,
    input  logic                   in_carry,
    input  logic                   in_overflow,
    input  logic                   clr_drop,
    output logic                   tx,
    output logic                   busy,
    output logic                   drop_sticky,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   LEVEL_FULL = DEPTH[AW:0];

    typedef enum logic {StIdle, StShift} state_e;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          drop_q;
    state_e        state_q, state_d;
    logic [12:0]   shreg_q, shreg_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic          push, pop, fifo_empty;
    logic [9:0]    head;
    logic [12:0]   head_frame;

    assign in_ready   = (level_q != LEVEL_FULL);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (level_q == '0);
    assign head       = mem[rd_ptr_q];
    // Bit 0 leaves first; the shift register refills with ones so tx idles high.
    assign head_frame = {1'b1, ^head, head, 1'b0};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_overflow, in_carry, in_result};
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            // A lost word wins over a simultaneous clear.
            if (in_valid && !in_ready) begin
                drop_q <= 1'b1;
            end else if (clr_drop) begin
                drop_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = head_frame;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd12) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shreg_d = head_frame;
                        end else begin
                            shreg_d = '1;
                            state_d = StIdle;
                        end
                    end else begin
                        shreg_d = {1'b1, shreg_q[12:1]};
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end

    assign tx          = shreg_q[0];
    assign busy        = (state_q == StShift);
    assign drop_sticky = drop_q;
    assign fifo_level  = level_q;

endmodule
